// File: rtl/beverage_pkg.sv
// Recipe table, ingredient/state encodings and recipe lookup helper for the beverage sequencer.
// Latency: n/a (constants and a combinational helper only).
// Backpressure: n/a.
package beverage_pkg;

    localparam int ING_COUNT     = 5;
    localparam int MAX_BASE_DOSE = 4;

    typedef enum logic [2:0] {
        ING_AGUA      = 3'd0,
        ING_CAFE      = 3'd1,
        ING_LECHE     = 3'd2,
        ING_CHOCOLATE = 3'd3,
        ING_AZUCAR    = 3'd4
    } ing_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DISPENSE,
        ST_GAP,
        ST_DONE,
        ST_ABORT
    } state_e;

    // Mask bit order follows ing_e; all-zero entries mark invalid drink codes.
    localparam logic [ING_COUNT-1:0] RECIPE_MASK [0:7] = '{
        5'b00000,   // 0 invalid
        5'b00011,   // 1 agua+cafe
        5'b00111,   // 2 agua+cafe+leche
        5'b01101,   // 3 agua+leche+chocolate
        5'b10011,   // 4 agua+cafe+azucar
        5'b10111,   // 5 agua+cafe+leche+azucar
        5'b00000,   // 6 invalid
        5'b00000    // 7 invalid
    };

    // Unscaled dose per ingredient, in clock cycles.
    localparam int unsigned BASE_DOSE [0:ING_COUNT-1] = '{4, 3, 2, 3, 1};

    function automatic logic recipe_valid(input logic [2:0] code);
        return RECIPE_MASK[code] != '0;
    endfunction

endpackage

// File: rtl/beverage_sequencer_if.sv
// Front-panel / valve-driver signal bundle for the beverage sequencer.
// Latency: n/a (wiring only). Optional sugar_lvl field under BEVERAGE_SUGAR_LEVEL_EN.
// Backpressure: none; start is a level-sampled request, status outputs are pulses/levels.
interface beverage_sequencer_if #(
    parameter int NUM_ING = 5,
    parameter int SEL_W   = 3
);
    logic [SEL_W-1:0]   sel;
    logic               start;
    logic               cancel;
`ifdef BEVERAGE_SUGAR_LEVEL_EN
    logic [1:0]         sugar_lvl;
`endif
    logic [NUM_ING-1:0] valve;
    logic               busy;
    logic               finish;
    logic               aborted;
    logic               err;

`ifdef BEVERAGE_SUGAR_LEVEL_EN
    modport master (output sel, start, cancel, sugar_lvl,
                    input  valve, busy, finish, aborted, err);
    modport slave  (input  sel, start, cancel, sugar_lvl,
                    output valve, busy, finish, aborted, err);
`else
    modport master (output sel, start, cancel,
                    input  valve, busy, finish, aborted, err);
    modport slave  (input  sel, start, cancel,
                    output valve, busy, finish, aborted, err);
`endif
endinterface

// File: rtl/lowest_bit_picker.sv
// Priority encoder: one-hot and index of the lowest set bit of the working mask.
// Latency: combinational.
// Backpressure: n/a.
module lowest_bit_picker #(
    parameter int N     = 5,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     mask_i,
    output logic [N-1:0]     onehot_o,
    output logic [IDX_W-1:0] idx_o
);
    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask_i[i]) begin
                onehot_o    = '0;
                onehot_o[i] = 1'b1;
                idx_o       = IDX_W'(i);
            end
        end
    end
endmodule

// File: rtl/beverage_sequencer.sv
// Drink sequencer: latches a recipe on start, doses one valve at a time with gaps, pulses finish/aborted/err.
// Latency: LOAD one cycle after accepted start, doses back-to-back or GAP_CYCLES apart, DONE one cycle.
// Backpressure: none; start/sel ignored while busy, cancel aborts. Optional sugar_lvl via BEVERAGE_SUGAR_LEVEL_EN.
module beverage_sequencer
    import beverage_pkg::*;
#(
    parameter int NUM_ING    = 5,
    parameter int SEL_W      = 3,
    parameter int DOSE_SCALE = 1,
    parameter int GAP_CYCLES = 1,
    parameter int TIME_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    beverage_sequencer_if.slave  bus
);
    localparam int IDX_W = $clog2(NUM_ING);
    localparam logic [TIME_W-1:0] GAP_LOAD = TIME_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [TIME_W-1:0] ONE      = TIME_W'(1);

    if (3 * MAX_BASE_DOSE * DOSE_SCALE >= 2 ** TIME_W) begin : g_time_w_check
        $error("TIME_W too narrow for scaled doses");
    end
    if (NUM_ING != ING_COUNT) begin : g_num_ing_check
        $error("NUM_ING must match the recipe table width");
    end
    if (SEL_W < 3) begin : g_sel_w_check
        $error("SEL_W must cover drink codes 0..7");
    end

    state_e             state_q, state_d;
    logic [NUM_ING-1:0] mask_q, mask_d;
    logic [NUM_ING-1:0] cur_q, cur_d;
    logic [TIME_W-1:0]  cnt_q, cnt_d;
    logic               err_q, err_d;
`ifdef BEVERAGE_SUGAR_LEVEL_EN
    logic [1:0]         sugar_q, sugar_d;
`endif

    logic [NUM_ING-1:0] pick_oh;
    logic [IDX_W-1:0]   pick_idx;
    logic [TIME_W-1:0]  pick_dose;
    logic [NUM_ING-1:0] start_mask;
    logic               sel_valid;

    lowest_bit_picker #(.N(NUM_ING), .IDX_W(IDX_W)) u_picker (
        .mask_i   (mask_q),
        .onehot_o (pick_oh),
        .idx_o    (pick_idx)
    );

    assign sel_valid = (32'(bus.sel) < 32'd8) && recipe_valid(bus.sel[2:0]);

    // Dose length of the ingredient about to be dispensed, and the mask captured at start.
    always_comb begin
        pick_dose  = TIME_W'(BASE_DOSE[pick_idx] * DOSE_SCALE);
        start_mask = RECIPE_MASK[bus.sel[2:0]];
`ifdef BEVERAGE_SUGAR_LEVEL_EN
        if (pick_idx == IDX_W'(ING_AZUCAR)) begin
            pick_dose = TIME_W'(32'(sugar_q) * DOSE_SCALE);
        end
        if (bus.sugar_lvl == 2'd0) begin
            start_mask[int'(ING_AZUCAR)] = 1'b0;
        end
`endif
    end

    // Next-state logic; cancel takes priority over every normal transition while brewing.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
`ifdef BEVERAGE_SUGAR_LEVEL_EN
        sugar_d = sugar_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (sel_valid) begin
                        state_d = ST_LOAD;
                        mask_d  = start_mask;
`ifdef BEVERAGE_SUGAR_LEVEL_EN
                        sugar_d = bus.sugar_lvl;
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (bus.cancel) begin
                    state_d = ST_ABORT;
                end else begin
                    state_d = ST_DISPENSE;
                    cur_d   = pick_oh;
                    mask_d  = mask_q & ~pick_oh;
                    cnt_d   = pick_dose - ONE;
                end
            end
            ST_DISPENSE: begin
                if (bus.cancel) begin
                    state_d = ST_ABORT;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - ONE;
                end else if (mask_q == '0) begin
                    state_d = ST_DONE;
                end else if (GAP_CYCLES > 0) begin
                    state_d = ST_GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cur_d  = pick_oh;
                    mask_d = mask_q & ~pick_oh;
                    cnt_d  = pick_dose - ONE;
                end
            end
            ST_GAP: begin
                if (bus.cancel) begin
                    state_d = ST_ABORT;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - ONE;
                end else begin
                    state_d = ST_DISPENSE;
                    cur_d   = pick_oh;
                    mask_d  = mask_q & ~pick_oh;
                    cnt_d   = pick_dose - ONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_ABORT: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset clears everything so valves drop without a clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            mask_q  <= '0;
            cur_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
`ifdef BEVERAGE_SUGAR_LEVEL_EN
            sugar_q <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            cur_q   <= cur_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`ifdef BEVERAGE_SUGAR_LEVEL_EN
            sugar_q <= sugar_d;
`endif
        end
    end

    // Outputs decode from registered state only, so they are glitch-free and one-hot by construction.
    assign bus.valve   = (state_q == ST_DISPENSE) ? cur_q : '0;
    assign bus.busy    = (state_q == ST_LOAD) || (state_q == ST_DISPENSE) ||
                         (state_q == ST_GAP)  || (state_q == ST_DONE);
    assign bus.finish  = (state_q == ST_DONE);
    assign bus.aborted = (state_q == ST_ABORT);
    assign bus.err     = err_q;

endmodule

// File: tb/tb_beverage_sequencer.sv
// Scoreboard bench: per-cycle expected valve/status vectors queued at start, popped each cycle.
// Latency: n/a.
// Backpressure: n/a.
module tb_beverage_sequencer;

    typedef struct packed {
        logic [4:0] valve;
        logic       busy;
        logic       finish;
        logic       aborted;
        logic       err;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    beverage_sequencer_if #(.NUM_ING(5), .SEL_W(3)) ifa ();
    beverage_sequencer_if #(.NUM_ING(5), .SEL_W(3)) ifb ();

    beverage_sequencer dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    beverage_sequencer #(.DOSE_SCALE(2), .GAP_CYCLES(0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    obs_t obs_a, obs_b, got, want;
    assign obs_a = {ifa.valve, ifa.busy, ifa.finish, ifa.aborted, ifa.err};
    assign obs_b = {ifb.valve, ifb.busy, ifb.finish, ifb.aborted, ifb.err};

    obs_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    int tb_dose [5] = '{4, 3, 2, 3, 1};

    function automatic void push_obs(input logic [4:0] v, input logic b, input logic f,
                                     input logic a, input logic e);
        obs_t o;
        o.valve = v; o.busy = b; o.finish = f; o.aborted = a; o.err = e;
        exp_q.push_back(o);
    endfunction

    // Expected trace of a full brew: LOAD, doses low bit first, gaps between doses, DONE, one idle cycle.
    function automatic void model_brew(input logic [4:0] mask, input int scale, input int gap,
                                       input int sugar_dose);
        push_obs(5'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (mask[i]) begin
                int d = (i == 4) ? sugar_dose : tb_dose[i] * scale;
                logic [4:0] vb = 5'(1 << i);
                repeat (d) push_obs(vb, 1'b1, 1'b0, 1'b0, 1'b0);
                if (((mask >> (i + 1)) != 5'b0) && gap > 0)
                    repeat (gap) push_obs(5'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            end
        end
        push_obs(5'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        push_obs(5'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    task automatic pulse_a(input logic [2:0] s);
        @(negedge clk);
        ifa.sel = s; ifa.start = 1'b1;
        @(posedge clk);
        #1 ifa.start = 1'b0;
    endtask

    task automatic pulse_b(input logic [2:0] s);
        @(negedge clk);
        ifb.sel = s; ifb.start = 1'b1;
        @(posedge clk);
        #1 ifb.start = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_vec++;
        if (obs_a !== 5'b0 || obs_b !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_state: got a=%b b=%b want 0", obs_a, obs_b);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            n_vec++;
            if (obs_a !== 5'b0) begin
                n_fail++;
                $display("FAIL reset_idle: got %b want 0", obs_a);
            end
        end
    endtask

    task automatic test_sel1();
        int cyc = 1;
        exp_q.delete();
        pulse_a(3'd1);
        model_brew(5'b00011, 1, 1, 1);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            got = obs_a; want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL sel1 cycle %0d: got %b want %b", cyc, got, want);
            end
            cyc++;
        end
    endtask

    task automatic test_scaled_nogap();
        int cyc = 1;
        exp_q.delete();
        pulse_b(3'd5);
        model_brew(5'b10111, 2, 0, 2);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            got = obs_b; want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL scaled_sel5 cycle %0d: got %b want %b", cyc, got, want);
            end
            cyc++;
        end
    endtask

    task automatic test_invalid();
        logic [2:0] codes [3] = '{3'd0, 3'd6, 3'd7};
        for (int k = 0; k < 3; k++) begin
            int cyc = 1;
            exp_q.delete();
            pulse_a(codes[k]);
            push_obs(5'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            push_obs(5'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            while (exp_q.size() > 0) begin
                @(negedge clk);
                got = obs_a; want = exp_q.pop_front(); n_vec++;
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL invalid_sel%0d cycle %0d: got %b want %b", codes[k], cyc, got, want);
                end
                cyc++;
            end
        end
    endtask

    task automatic test_cancel();
        int cyc = 1;
        exp_q.delete();
        pulse_a(3'd3);
        push_obs(5'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (4) push_obs(5'b00001, 1'b1, 1'b0, 1'b0, 1'b0);
        push_obs(5'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (2) push_obs(5'b00100, 1'b1, 1'b0, 1'b0, 1'b0);
        push_obs(5'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        push_obs(5'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push_obs(5'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            got = obs_a; want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL cancel cycle %0d: got %b want %b", cyc, got, want);
            end
            ifa.cancel = (cyc == 8);
            cyc++;
        end
        ifa.cancel = 1'b0;
        cyc = 1;
        pulse_a(3'd1);
        model_brew(5'b00011, 1, 1, 1);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            got = obs_a; want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL restart_after_cancel cycle %0d: got %b want %b", cyc, got, want);
            end
            cyc++;
        end
    endtask

    task automatic test_back_to_back();
        int cyc = 1;
        exp_q.delete();
        pulse_a(3'd1);
        model_brew(5'b00011, 1, 1, 1);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            got = obs_a; want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL restart_ignored cycle %0d: got %b want %b", cyc, got, want);
            end
            if (cyc == 4) begin
                ifa.sel = 3'd2; ifa.start = 1'b1;
            end else begin
                ifa.start = 1'b0;
            end
            cyc++;
        end
        ifa.start = 1'b0;
    endtask

    task automatic test_reset_mid();
        exp_q.delete();
        pulse_a(3'd1);
        model_brew(5'b00011, 1, 1, 1);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            got = obs_a; want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL pre_reset cycle %0d: got %b want %b", c, got, want);
            end
        end
        exp_q.delete();
        #2 rst = 1'b0;
        #1;
        n_vec++;
        if (ifa.valve !== 5'b0 || ifa.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got valve=%b busy=%b want 00000 0", ifa.valve, ifa.busy);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

`ifdef BEVERAGE_SUGAR_LEVEL_EN
    task automatic test_sugar();
        logic [1:0] lvls [2] = '{2'd0, 2'd3};
        for (int k = 0; k < 2; k++) begin
            int cyc = 1;
            exp_q.delete();
            ifa.sugar_lvl = lvls[k];
            pulse_a(3'd4);
            if (lvls[k] == 2'd0) model_brew(5'b00011, 1, 1, 0);
            else                 model_brew(5'b10011, 1, 1, 3);
            while (exp_q.size() > 0) begin
                @(negedge clk);
                got = obs_a; want = exp_q.pop_front(); n_vec++;
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL sugar%0d cycle %0d: got %b want %b", lvls[k], cyc, got, want);
                end
                cyc++;
            end
        end
        ifa.sugar_lvl = 2'd1;
    endtask
`endif

    initial begin
        ifa.sel = 3'd0; ifa.start = 1'b0; ifa.cancel = 1'b0;
        ifb.sel = 3'd0; ifb.start = 1'b0; ifb.cancel = 1'b0;
`ifdef BEVERAGE_SUGAR_LEVEL_EN
        ifa.sugar_lvl = 2'd1;
        ifb.sugar_lvl = 2'd1;
`endif
        test_reset();
        test_sel1();
        test_scaled_nogap();
        test_invalid();
        test_cancel();
        test_back_to_back();
        test_reset_mid();
`ifdef BEVERAGE_SUGAR_LEVEL_EN
        test_sugar();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, want completion");
        $fatal(1, "timeout");
    end

endmodule
